// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_arbiter
// Description : Two-requester round-robin arbiter in front of a registered
//               carry-lookahead add/subtract unit. The winner's operands are
//               captured at grant time and the result is presented one
//               cycle later with a valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module add_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             valid,
  output logic             owner,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int GROUPS = WIDTH / 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic [0:0] state;
  logic [0:0] next_state;
  logic       any_req;
  logic       accept;
  logic       complete;
  logic       winner;
  logic       last_winner;

  // Captured operation of the current winner
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_sub;
  logic             cap_owner;

  assign any_req = req0 | req1;

  // Round-robin pick: a lone requester wins, a tie goes to the one that did
  // not win the previous grant.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_winner;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: requests are only looked at while idle
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = S_EXEC;
      S_EXEC:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded controls: accept a request, complete the operation
  always_comb begin
    busy     = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      S_IDLE:  accept = any_req;
      S_EXEC: begin
        busy     = 1'b1;
        complete = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant pulses, round-robin memory and operand capture at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      last_winner <= 1'b1;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_sub     <= 1'b0;
      cap_owner   <= 1'b0;
    end else begin
      gnt0 <= accept & ~winner;
      gnt1 <= accept & winner;
      if (accept) begin
        last_winner <= winner;
        cap_owner   <= winner;
        cap_a       <= winner ? a1 : a0;
        cap_b       <= winner ? b1 : b0;
        cap_sub     <= winner ? sub1 : sub0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Carry-lookahead adder on the captured operands.
  // Subtraction is a + ~b + 1.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  op_b;
  logic              cin;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS:0]   grp_c;
  logic [WIDTH-1:0]  sum_w;
  logic              c_msb;
  logic              la_acc;
  logic              la_pp;

  assign op_b = cap_sub ? ~cap_b : cap_b;
  assign cin  = cap_sub;

  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_group
      logic [3:0] p;
      logic [3:0] g;
      logic [3:0] c;

      assign p = cap_a[4*gi +: 4] ^ op_b[4*gi +: 4];
      assign g = cap_a[4*gi +: 4] & op_b[4*gi +: 4];

      // Group propagate/generate feed the inter-group lookahead
      assign grp_p[gi] = &p;
      assign grp_g[gi] = g[3]
                       | (p[3] & g[2])
                       | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);

      // Bit carries inside the group, all from the group carry-in
      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);

      assign sum_w[4*gi +: 4] = p ^ c;

      // Carry into the sign bit is needed for overflow detection
      if (gi == GROUPS - 1) begin : g_msb
        assign c_msb = c[3];
      end
    end
  endgenerate

  // Group carries: each one is a flat sum-of-products of lower group G/P
  // terms and cin, so no carry ripples from group to group.
  always_comb begin
    grp_c    = '0;
    la_acc   = 1'b0;
    la_pp    = 1'b1;
    grp_c[0] = cin;
    for (int k = 1; k <= GROUPS; k++) begin
      la_acc = 1'b0;
      la_pp  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        la_acc = la_acc | (la_pp & grp_g[j]);
        la_pp  = la_pp & grp_p[j];
      end
      grp_c[k] = la_acc | (la_pp & cin);
    end
  end

  // Result registers: written once per operation, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      owner <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      valid <= complete;
      if (complete) begin
        owner <= cap_owner;
        sum   <= sum_w;
        cout  <= grp_c[GROUPS];
        ovf   <= grp_c[GROUPS] ^ c_msb;
        zero  <= (sum_w == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_arbiter
// Description : Self-checking bench for add_arbiter: directed cases followed
//               by randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_arbiter;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         sub0, sub1;
  logic         gnt0, gnt1, busy, valid, owner;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int n_tests;
  int n_fail;

  add_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .sub0  (sub0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .sub1  (sub1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy),
    .valid (valid),
    .owner (owner),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic straight from integer semantics
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r_sum, output logic r_cout,
                        output logic r_ovf, output logic r_zero);
    int unsigned ua, ub, t;
    int          sa, sb, r;
    ua = {16'b0, a};
    ub = {16'b0, b};
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    if (s) begin
      t      = ua - ub;
      r      = sa - sb;
      r_cout = (ua >= ub);
    end else begin
      t      = ua + ub;
      r      = sa + sb;
      r_cout = t[16];
    end
    r_sum  = t[15:0];
    r_ovf  = (r > 32767) || (r < -32768);
    r_zero = (r_sum == 16'h0000);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Assert reset for two cycles and check every output is cleared
  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outs", {11'b0, gnt0, gnt1, busy, valid, owner, cout, ovf, zero, sum}, 32'h0);
    rst_n = 1'b1;
  endtask

  // One isolated operation from requester idx with spec-given expectations
  task automatic run_single(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] x_sum, input logic x_cout,
                            input logic x_ovf, input logic x_zero);
    if (idx) begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
    @(negedge clk);
    check("d_gnt0", gnt0, !idx);
    check("d_gnt1", gnt1, idx);
    check("d_busy", busy, 1);
    check("d_valid_early", valid, 0);
    // drop request and disturb operands; the in-flight result must not change
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; sub0 = !s; sub1 = !s;
    @(negedge clk);
    check("d_valid", valid, 1);
    check("d_gnt_off", {gnt0, gnt1}, 0);
    check("d_sum", sum, x_sum);
    check("d_cout", cout, x_cout);
    check("d_ovf", ovf, x_ovf);
    check("d_zero", zero, x_zero);
    check("d_owner", owner, idx);
    @(negedge clk);
    check("d_valid_pulse", valid, 0);
    check("d_sum_hold", sum, x_sum);
  endtask

  // Model state for the random phase
  logic         m_busy, m_last, w;
  logic [W-1:0] p_a, p_b;
  logic         p_s, p_o;
  logic         e_gnt0, e_gnt1, e_valid, e_owner, e_cout, e_ovf, e_zero;
  logic [W-1:0] e_sum;
  int           ops, cyc, wait0, wait1;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sub0 = 1'b0; sub1 = 1'b0;

    // Reset values, then first request right at the first edge after release
    do_reset();
    run_single(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_single(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_single(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_single(1'b1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_single(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Both requesters held high from reset: 0,1,0,1 with results between
    do_reset();
    req0 = 1'b1; a0 = 16'd1;  b0 = 16'd2; sub0 = 1'b0;
    req1 = 1'b1; a1 = 16'd10; b1 = 16'd3; sub1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_gnt_excl", gnt0 & gnt1, 0);
      if (i % 2 == 0) begin
        check("rr_gnt0", gnt0, ((i / 2) % 2) == 0);
        check("rr_gnt1", gnt1, ((i / 2) % 2) == 1);
        check("rr_valid_lo", valid, 0);
      end else begin
        check("rr_valid", valid, 1);
        check("rr_owner", owner, ((i / 2) % 2) == 1);
        check("rr_sum", sum, (((i / 2) % 2) == 1) ? 32'd7 : 32'd3);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Reset landing on an in-flight operation
    do_reset();
    req0 = 1'b1; a0 = 16'h0011; b0 = 16'h0022; sub0 = 1'b0;
    @(negedge clk);
    check("ri_gnt0", gnt0, 1);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("ri_outs", {11'b0, gnt0, gnt1, busy, valid, owner, cout, ovf, zero, sum}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ri_no_valid", valid, 0);
    check("ri_busy", busy, 0);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 16'h0100; b0 = 16'h0001; sub0 = 1'b1;
    @(negedge clk);
    check("ri_tie_gnt0", gnt0, 1);
    check("ri_tie_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("ri_valid", valid, 1);
    check("ri_owner", owner, 0);
    check("ri_sum", sum, 32'h00FF);

    // Randomized traffic against the transaction model
    do_reset();
    m_busy = 1'b0; m_last = 1'b1;
    e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0; e_owner = 1'b0;
    ops = 0; cyc = 0; wait0 = 0; wait1 = 0;
    while (ops < 10000 && cyc < 60000) begin
      @(posedge clk);
      cyc++;
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_valid = 1'b0;
      if (m_busy) begin
        ref_op(p_a, p_b, p_s, e_sum, e_cout, e_ovf, e_zero);
        e_owner = p_o;
        e_valid = 1'b1;
        m_busy  = 1'b0;
        ops++;
      end else if (req0 || req1) begin
        w = (req0 && req1) ? !m_last : req1;
        p_a = w ? a1 : a0;
        p_b = w ? b1 : b0;
        p_s = w ? sub1 : sub0;
        p_o = w;
        e_gnt0 = !w; e_gnt1 = w;
        m_last = w;
        m_busy = 1'b1;
      end
      @(negedge clk);
      check("r_gnt0", gnt0, e_gnt0);
      check("r_gnt1", gnt1, e_gnt1);
      check("r_valid", valid, e_valid);
      check("r_busy", busy, m_busy);
      check("r_gnt_valid_excl", valid & (gnt0 | gnt1), 0);
      check("r_sum", sum, e_sum);
      check("r_flags", {cout, ovf, zero}, {e_cout, e_ovf, e_zero});
      check("r_owner", owner, e_owner);
      // Starvation: a waiting requester may see at most one grant to the other
      if (gnt1 && req0) wait0++;
      if (gnt0 && req1) wait1++;
      if (gnt0) wait0 = 0;
      if (gnt1) wait1 = 0;
      if (gnt0 || gnt1) check("r_starve", {wait0 > 1, wait1 > 1}, 0);

      // New stimulus for the next edge
      if (e_gnt0) begin
        req0 = ($urandom_range(0, 1) == 1);
        a0 = rand_operand(); b0 = rand_operand(); sub0 = $urandom_range(0, 1) == 1;
      end else if (!req0 && $urandom_range(0, 2) != 0) begin
        req0 = 1'b1;
        a0 = rand_operand(); b0 = rand_operand(); sub0 = $urandom_range(0, 1) == 1;
      end
      if (e_gnt1) begin
        req1 = ($urandom_range(0, 1) == 1);
        a1 = rand_operand(); b1 = rand_operand(); sub1 = $urandom_range(0, 1) == 1;
      end else if (!req1 && $urandom_range(0, 2) != 0) begin
        req1 = 1'b1;
        a1 = rand_operand(); b1 = rand_operand(); sub1 = $urandom_range(0, 1) == 1;
      end
    end
    check("r_ops_done", (ops >= 10000), 1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; a multiple of 4, one carry-lookahead group per 4 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0 / req1  input  1  requester 0/1 operation request; held high until matching grant seen.
REQ-005 a0, b0 / a1, b1  input  WIDTH  requester operands; valid while req high.
REQ-006 sub0 / sub1  input  1  1 = a-b, 0 = a+b.
REQ-007 gnt0 / gnt1  output  1  registered one-cycle grant pulse; operands captured at the edge that raised it.
REQ-008 busy  output  1  high while an accepted operation is in flight (state EXEC).
REQ-009 valid  output  1  one-cycle pulse; result outputs meaningful.
REQ-010 owner  output  1  requester index of the result presented with valid.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout, ovf, zero  output  1 each  carry-out, signed overflow, result==0.

Function
REQ-013 States: IDLE, EXEC; reset state IDLE.
REQ-014 IDLE, no req: stay IDLE; all pulses low.
REQ-015 IDLE, any req at edge: capture winner's a, b, sub, index; raise its gnt for exactly one cycle; go EXEC.
REQ-016 Arbitration round-robin: single requester always wins; both requesting -> requester that did not win last grant wins; last-winner register resets to 1 (requester 0 wins first tie).
REQ-017 EXEC: next edge writes sum/cout/ovf/zero/owner, pulses valid one cycle, returns IDLE; req ignored in EXEC.
REQ-018 Latency: req sampled at edge N -> gnt high cycle N..N+1, valid high cycle N+1..N+2; peak throughput one op per 2 cycles.
REQ-019 req still high at the IDLE edge following a grant is a new request (arbitrated normally).
REQ-020 Adder: WIDTH/4 4-bit groups, each producing group propagate/generate; group carries by lookahead across groups; result identical to a+b+cin mod 2^WIDTH.
REQ-021 Add: cin=0, operand b. Sub: b inverted, cin=1.
REQ-022 cout = carry out of MSB (sub: 1 means no borrow); ovf = carry into MSB XOR carry out of MSB; zero = (sum==0).
REQ-023 sum, cout, ovf, zero, owner hold value until next valid.
REQ-024 gnt0 and gnt1 never high together; valid and gnt never high together.
REQ-025 Operand changes after grant do not affect the in-flight result.

Reset
REQ-026 rst_n low: state IDLE; gnt0, gnt1, busy, valid, owner, cout, ovf, zero = 0; sum = 0; last-winner = 1; captured operands = 0.
REQ-027 Reset during EXEC: operation discarded, no valid after release.
REQ-028 First request accepted at first rising edge with rst_n high.

Verification
REQ-029 req0, a0=0x1234, b0=0x4321, sub0=0 -> gnt0 one cycle, next cycle valid, sum=0x5555, owner=0, cout=0, ovf=0, zero=0.
REQ-030 req1, a1=0x7FFF, b1=0x0001, sub1=0 -> sum=0x8000, ovf=1, cout=0; then a1=0xFFFF, b1=0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0.
REQ-031 req1, a1=0x0005, b1=0x0005, sub1=1 -> sum=0x0000, zero=1, cout=1; a1=0x0003, b1=0x0005, sub1=1 -> sum=0xFFFE, cout=0.
REQ-032 req0 and req1 held high continuously from reset -> grant order 0,1,0,1; valid every 2nd cycle with owner alternating; gnt never overlap.
REQ-033 rst_n pulsed low the cycle after a grant -> no valid pulse, all outputs 0, next request served normally with requester 0 winning a tie.
REQ-034 Random a/b/sub, random req patterns, 10k ops -> every result matches reference a±b with correct cout/ovf/zero and owner; no request starved beyond one intervening grant.
